// File: rtl/axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi_write_arbiter
//   Write-path arbiter/sequencer for a 2-master x 4-slave AXI interconnect.
//   Grants one master the write path, decodes its AWADDR to a slave, and drives
//   the state/route controls used by the AW/W/B channel muxes. Exactly one write
//   transaction (AW -> W burst -> B) is in flight at a time; the path is released
//   back to IDLE after the B handshake.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   AWVALID/AWADDR/AWLEN_Mx       AW request, address and burst length-1 per master
//   AWREADY_Mx                    AWREADY as returned to each master by the AW mux
//   WVALID/WREADY/WLAST_Mx        W channel handshake per master
//   BVALID/BREADY_Mx              B channel handshake per master
//   Arbiter_Write_State_control   00 addr/idle, 01 data, 10 response
//   Arbiter_AWID_control          route {master, slave[2:0]}; 4'h7 = no route
//   write_busy                    high whenever a transaction is in progress
//   wlast_err                     1-cycle pulse when WLAST disagrees with AWLEN+1
// -----------------------------------------------------------------------------
module axi_write_arbiter #(
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h0002_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_BASE = 32'h1000_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_FC00,
  parameter logic [31:0] S4_BASE = 32'h2000_0000,
  parameter logic [31:0] S4_MASK = 32'hFFE0_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWVALID_M0,
  input  logic        AWVALID_M1,
  input  logic [31:0] AWADDR_M0,
  input  logic [31:0] AWADDR_M1,
  input  logic [3:0]  AWLEN_M0,
  input  logic [3:0]  AWLEN_M1,
  input  logic        AWREADY_M0,
  input  logic        AWREADY_M1,
  input  logic        WVALID_M0,
  input  logic        WVALID_M1,
  input  logic        WREADY_M0,
  input  logic        WREADY_M1,
  input  logic        WLAST_M0,
  input  logic        WLAST_M1,
  input  logic        BVALID_M0,
  input  logic        BVALID_M1,
  input  logic        BREADY_M0,
  input  logic        BREADY_M1,
  output logic [1:0]  Arbiter_Write_State_control,
  output logic [3:0]  Arbiter_AWID_control,
  output logic        write_busy,
  output logic        wlast_err
);

  // Internal sequencer states. IDLE and ADDR share the 00 control code, so the
  // control output is kept as its own register rather than derived from these.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] CTL_ADDR = 2'b00;
  localparam logic [1:0] CTL_DATA = 2'b01;
  localparam logic [1:0] CTL_RESP = 2'b10;

  localparam logic [3:0] AWID_NONE = 4'h7;

  logic [1:0] state_q,    state_d;
  logic       grant_q,    grant_d;     // 0 = M0, 1 = M1
  logic [2:0] slave_q,    slave_d;     // 0 = default slave, 1..4 = S1..S4
  logic [3:0] len_q,      len_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] ctl_q,      ctl_d;
  logic [3:0] awid_q,     awid_d;
  logic       busy_q,     busy_d;
  logic       err_q,      err_d;

  // First matching window wins; windows do not overlap, so order only matters
  // for documentation. No match routes to the default slave.
  function automatic logic [2:0] decode_slave(input logic [31:0] addr);
    if      ((addr & S1_MASK) == S1_BASE) return 3'd1;
    else if ((addr & S2_MASK) == S2_BASE) return 3'd2;
    else if ((addr & S3_MASK) == S3_BASE) return 3'd3;
    else if ((addr & S4_MASK) == S4_BASE) return 3'd4;
    else                                   return 3'd0;
  endfunction

  // Handshakes seen from the granted master only; the other master is invisible
  // once a grant is held.
  logic aw_hs, w_hs, w_last, b_hs;
  assign aw_hs  = grant_q ? (AWVALID_M1 & AWREADY_M1) : (AWVALID_M0 & AWREADY_M0);
  assign w_hs   = grant_q ? (WVALID_M1  & WREADY_M1)  : (WVALID_M0  & WREADY_M0);
  assign w_last = grant_q ? WLAST_M1 : WLAST_M0;
  assign b_hs   = grant_q ? (BVALID_M1  & BREADY_M1)  : (BVALID_M0  & BREADY_M0);

  // Fixed priority M0 > M1 in IDLE.
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  assign req_addr = AWVALID_M0 ? AWADDR_M0 : AWADDR_M1;
  assign req_len  = AWVALID_M0 ? AWLEN_M0  : AWLEN_M1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    slave_d    = slave_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    ctl_d      = ctl_q;
    awid_d     = awid_q;
    busy_d     = busy_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (AWVALID_M0 || AWVALID_M1) begin
          grant_d = ~AWVALID_M0;
          slave_d = decode_slave(req_addr);
          len_d   = req_len;
          awid_d  = {grant_d, slave_d};
          ctl_d   = CTL_ADDR;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        // Grant is held even if the granted master drops AWVALID.
        if (aw_hs) begin
          beat_cnt_d = 4'd0;
          ctl_d      = CTL_DATA;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_hs) begin
          // beat_cnt_q is the zero-based index of the beat being accepted.
          beat_cnt_d = (beat_cnt_q == 4'hF) ? 4'hF : beat_cnt_q + 4'd1;
          if (w_last) begin
            err_d   = (beat_cnt_q != len_q);
            ctl_d   = CTL_RESP;
            state_d = ST_RESP;
          end else begin
            // Expected last beat arrived without WLAST; keep waiting for WLAST.
            err_d = (beat_cnt_q == len_q);
          end
        end
      end

      ST_RESP: begin
        if (b_hs) begin
          awid_d  = AWID_NONE;
          ctl_d   = CTL_ADDR;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        awid_d  = AWID_NONE;
        ctl_d   = CTL_ADDR;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      slave_q    <= 3'd0;
      len_q      <= 4'd0;
      beat_cnt_q <= 4'd0;
      ctl_q      <= CTL_ADDR;
      awid_q     <= AWID_NONE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      slave_q    <= slave_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      ctl_q      <= ctl_d;
      awid_q     <= awid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign Arbiter_Write_State_control = ctl_q;
  assign Arbiter_AWID_control        = awid_q;
  assign write_busy                  = busy_q;
  assign wlast_err                   = err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_write_arbiter
//   Directed scenarios with literal expectations followed by randomized traffic.
//   A transaction-level model tracks phase, grant, route and beat count and is
//   compared against the DUT outputs on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi_write_arbiter;

  logic        ACLK;
  logic        rst_n;
  logic [1:0]  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr [2];
  logic [3:0]  awlen  [2];

  logic [1:0]  state_ctl;
  logic [3:0]  awid;
  logic        busy;
  logic        werr;

  axi_write_arbiter dut (
    .ACLK                        (ACLK),
    .ARESETn                     (rst_n),
    .AWVALID_M0                  (awvalid[0]),
    .AWVALID_M1                  (awvalid[1]),
    .AWADDR_M0                   (awaddr[0]),
    .AWADDR_M1                   (awaddr[1]),
    .AWLEN_M0                    (awlen[0]),
    .AWLEN_M1                    (awlen[1]),
    .AWREADY_M0                  (awready[0]),
    .AWREADY_M1                  (awready[1]),
    .WVALID_M0                   (wvalid[0]),
    .WVALID_M1                   (wvalid[1]),
    .WREADY_M0                   (wready[0]),
    .WREADY_M1                   (wready[1]),
    .WLAST_M0                    (wlast[0]),
    .WLAST_M1                    (wlast[1]),
    .BVALID_M0                   (bvalid[0]),
    .BVALID_M1                   (bvalid[1]),
    .BREADY_M0                   (bready[0]),
    .BREADY_M1                   (bready[1]),
    .Arbiter_Write_State_control (state_ctl),
    .Arbiter_AWID_control        (awid),
    .write_busy                  (busy),
    .wlast_err                   (werr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transaction at a time, described by its phase.
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_ADDR, P_DATA, P_RESP} phase_t;

  localparam logic [31:0] BASES [4] = '{32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [31:0] MASKS [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FC00, 32'hFFE0_0000};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & MASKS[i]) == BASES[i]) return i + 1;
    return 0;
  endfunction

  phase_t m_phase  = P_IDLE;
  int     m_master = 0;
  int     m_slave  = 0;
  int     m_len    = 0;
  int     m_beats  = 0;   // beats accepted so far in this burst (unbounded)
  bit     m_err    = 1'b0;

  always @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_beats <= 0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      case (m_phase)
        P_IDLE:
          if (awvalid != 2'b00) begin
            m_master <= awvalid[0] ? 0 : 1;
            m_slave  <= decode(awvalid[0] ? awaddr[0] : awaddr[1]);
            m_len    <= awvalid[0] ? int'(awlen[0]) : int'(awlen[1]);
            m_phase  <= P_ADDR;
          end
        P_ADDR:
          if (awvalid[m_master] && awready[m_master]) begin
            m_beats <= 0;
            m_phase <= P_DATA;
          end
        P_DATA:
          if (wvalid[m_master] && wready[m_master]) begin
            m_beats <= m_beats + 1;
            // A 4-bit counter cannot name beats past the 16th.
            if (wlast[m_master]) begin
              m_err   <= ((m_beats > 15 ? 15 : m_beats) != m_len);
              m_phase <= P_RESP;
            end else begin
              m_err   <= ((m_beats > 15 ? 15 : m_beats) == m_len);
            end
          end
        P_RESP:
          if (bvalid[m_master] && bready[m_master]) m_phase <= P_IDLE;
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Compare process: all outputs are registered, so the falling edge is stable.
  always @(negedge ACLK) begin
    if (cmp_en) begin
      check("model_state", 32'(state_ctl),
            (m_phase == P_DATA) ? 32'd1 : (m_phase == P_RESP) ? 32'd2 : 32'd0);
      check("model_awid", 32'(awid),
            (m_phase == P_IDLE) ? 32'h7 : 32'(m_master * 8 + m_slave));
      check("model_busy", 32'(busy), 32'(m_phase != P_IDLE));
      check("model_wlast_err", 32'(werr), 32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic clr();
    awvalid = '0; awready = '0; wvalid = '0; wready = '0;
    wlast   = '0; bvalid  = '0; bready = '0;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [3:0] l);
    awvalid[m] = 1'b1;
    awaddr[m]  = a;
    awlen[m]   = l;
  endtask

  task automatic beat(input int m, input logic last);
    wvalid[m] = 1'b1;
    wready[m] = 1'b1;
    wlast[m]  = last;
  endtask

  localparam logic [31:0] ADDR_TBL [10] = '{
    32'h0001_0000, 32'h0001_FFFF, 32'h0002_0040, 32'h1000_0000, 32'h1000_03FF,
    32'h1000_0400, 32'h2000_0100, 32'h201F_FFFF, 32'h2020_0000, 32'h3000_0000
  };

  initial begin
    rst_n = 1'b0;
    awaddr[0] = '0; awaddr[1] = '0; awlen[0] = '0; awlen[1] = '0;
    clr();
    cyc(3);
    check("reset_state", 32'(state_ctl), 32'h0);
    check("reset_awid",  32'(awid),      32'h7);
    check("reset_busy",  32'(busy),      32'h0);
    check("reset_werr",  32'(werr),      32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // M0 single-beat write to DM.
    req(0, 32'h0002_0040, 4'd0);
    cyc();
    check("t2_awid", 32'(awid), 32'h2);
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_addr_state", 32'(state_ctl), 32'h0);
    awready[0] = 1'b1;
    cyc();
    check("t2_data_state", 32'(state_ctl), 32'h1);
    clr(); beat(0, 1'b1);
    cyc();
    check("t2_resp_state", 32'(state_ctl), 32'h2);
    check("t2_werr", 32'(werr), 32'h0);
    clr(); bvalid[0] = 1'b1; bready[0] = 1'b1;
    cyc();
    check("t2_idle_state", 32'(state_ctl), 32'h0);
    check("t2_idle_awid",  32'(awid),      32'h7);
    check("t2_idle_busy",  32'(busy),      32'h0);
    clr(); cyc();

    // Simultaneous requests: M0 wins, M1 handshakes meanwhile are ignored.
    req(0, 32'h0001_0000, 4'd0);
    req(1, 32'h2000_0100, 4'd0);
    awready[1] = 1'b1;
    cyc();
    check("t3_m0_first", 32'(awid), 32'h1);
    awready[0] = 1'b1;
    cyc();
    check("t3_m0_data",  32'(state_ctl), 32'h1);
    check("t3_awid_held", 32'(awid), 32'h1);
    awvalid[0] = 1'b0; awready[0] = 1'b0;
    bvalid[1] = 1'b1; bready[1] = 1'b1;
    beat(0, 1'b1);
    cyc();
    check("t3_m0_resp", 32'(state_ctl), 32'h2);
    wvalid = '0; wready = '0; wlast = '0;
    bvalid = 2'b01; bready = 2'b01;
    cyc();
    check("t3_gap_awid", 32'(awid), 32'h7);
    bvalid = '0; bready = '0;
    cyc();
    check("t3_m1_awid", 32'(awid), 32'hC);
    cyc();
    check("t3_m1_data", 32'(state_ctl), 32'h1);
    clr(); beat(1, 1'b1);
    cyc();
    clr(); bvalid[1] = 1'b1; bready[1] = 1'b1;
    cyc();
    check("t3_m1_idle", 32'(state_ctl), 32'h0);
    clr(); cyc();

    // M1 to an unmapped address goes to the default slave.
    req(1, 32'h3000_0000, 4'd0);
    awready[1] = 1'b1;
    cyc();
    check("t4_awid", 32'(awid), 32'h8);
    cyc();
    clr(); beat(1, 1'b1);
    cyc();
    clr(); bvalid[1] = 1'b1; bready[1] = 1'b1;
    cyc();
    check("t4_idle_awid", 32'(awid), 32'h7);
    clr(); cyc();

    // Early WLAST: AWLEN=3 but WLAST on the second beat.
    req(0, 32'h1000_0000, 4'd3);
    awready[0] = 1'b1;
    cyc();
    check("t5_awid", 32'(awid), 32'h3);
    cyc();
    clr(); beat(0, 1'b0);
    cyc();
    check("t5_beat1_werr", 32'(werr), 32'h0);
    check("t5_beat1_state", 32'(state_ctl), 32'h1);
    wlast[0] = 1'b1;
    cyc();
    check("t5_err_pulse", 32'(werr), 32'h1);
    check("t5_resp_state", 32'(state_ctl), 32'h2);
    clr();
    cyc();
    check("t5_err_cleared", 32'(werr), 32'h0);
    bvalid[0] = 1'b1; bready[0] = 1'b1;
    cyc();
    clr(); cyc();

    // Reset mid-burst, then a clean M1 transaction.
    req(0, 32'h0002_0000, 4'd3);
    awready[0] = 1'b1;
    cyc(2);
    clr(); beat(0, 1'b0);
    cyc(2);
    clr();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(state_ctl), 32'h0);
    check("t6_rst_awid",  32'(awid),      32'h7);
    check("t6_rst_busy",  32'(busy),      32'h0);
    check("t6_rst_werr",  32'(werr),      32'h0);
    cyc(2);
    rst_n = 1'b1;
    req(1, 32'h0002_0000, 4'd1);
    awready[1] = 1'b1;
    cyc();
    check("t6_m1_awid", 32'(awid), 32'hA);
    cyc();
    clr(); beat(1, 1'b0);
    cyc();
    wlast[1] = 1'b1;
    cyc();
    check("t6_count_restart", 32'(werr), 32'h0);
    check("t6_resp_state", 32'(state_ctl), 32'h2);
    clr(); bvalid[1] = 1'b1; bready[1] = 1'b1;
    cyc();
    clr(); cyc();

    // Randomized traffic on both masters, checked cycle by cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      for (int m = 0; m < 2; m++) begin
        awvalid[m] = ($urandom_range(0, 3) == 0);
        awaddr[m]  = ADDR_TBL[$urandom_range(0, 9)] +
                     (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : 32'd0);
        awlen[m]   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3));
        awready[m] = $urandom_range(0, 1) == 1;
        wvalid[m]  = $urandom_range(0, 3) != 0;
        wready[m]  = $urandom_range(0, 3) != 0;
        wlast[m]   = $urandom_range(0, 3) == 0;
        bvalid[m]  = $urandom_range(0, 1) == 1;
        bready[m]  = $urandom_range(0, 1) == 1;
      end
      cyc();
    end

    clr();
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
